bcd2bin_seq: RTL and testbench
==============================

BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-002 The block SHALL have parameter NDIG, default 4: number of packed BCD input digits.
REQ-003 The block SHALL have parameter BW, default 14: binary output width; BW SHALL satisfy 2^BW > 10^NDIG - 1.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port start  input  1  conversion request, sampled only in IDLE.
REQ-007 The block SHALL have port bcd_in  input  4*NDIG  packed BCD, most significant digit in the top nibble.
REQ-008 The block SHALL have port busy  output  1  high while a conversion is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse that marks bin_out valid.
REQ-010 The block SHALL have port bin_out  output  BW  converted binary value.
REQ-011 The block SHALL have port err  output  1  invalid-digit flag, valid together with done.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CONV and DONE.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL capture bcd_in into an internal shift register, clear the accumulator and the digit counter, and enter CONV.
REQ-014 In CONV, each cycle SHALL process one digit, most significant first: acc <= acc*10 + digit, computed at BW bits with no overflow possible given REQ-003.
REQ-015 After NDIG CONV cycles, the FSM SHALL enter DONE; in DONE, done=1 for exactly one cycle and bin_out SHALL take the accumulator value; the FSM then returns to IDLE.
REQ-016 Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k+NDIG+1 (5 cycles for NDIG=4).
REQ-017 busy SHALL be 1 in CONV and DONE and 0 in IDLE.
REQ-018 start in CONV or DONE SHALL be ignored and SHALL NOT queue a request.
REQ-019 start held high continuously SHALL produce back-to-back conversions, one every NDIG+2 cycles.
REQ-020 bcd_in changes after the capture edge SHALL NOT affect the result in flight.
REQ-021 bin_out and err SHALL hold their values from done until the next DONE state.
REQ-022 All-zero input SHALL produce bin_out=0; all-nines input SHALL produce 10^NDIG-1.

Reset
REQ-023 When rst_n=0, the block SHALL asynchronously force state=IDLE, busy=0, done=0, bin_out=0, err=0, and clear the accumulator, digit counter and shift register.
REQ-024 Reset asserted mid-CONV SHALL abort the conversion; no done pulse SHALL follow the release of reset.
REQ-025 After rst_n deasserts, the first start SHALL be accepted at the first rising edge where it is sampled high.

Configuration
REQ-026 With macro BCD2BIN_DIGIT_CHECK_EN defined, any captured digit greater than 9 SHALL set err=1 in DONE and force bin_out=0 for that result.
REQ-027 Without BCD2BIN_DIGIT_CHECK_EN, the err port SHALL remain present and tied to 0, and nibbles greater than 9 SHALL be accumulated at face value with no checking logic synthesized.

Verification
REQ-028 bcd_in=16'h2024 with a start pulse -> done in the 5th cycle after the start edge, bin_out=14'd2024 (0x07E8), err=0.
REQ-029 bcd_in=16'h9999 -> bin_out=14'd9999 (0x270F); bcd_in=16'h0000 -> bin_out=0.
REQ-030 start pulsed again 2 cycles after an accepted start with a different bcd_in -> exactly one done, carrying the first value; busy=1 throughout.
REQ-031 rst_n driven low in CONV cycle 2 -> busy, done and bin_out go to 0 immediately; no done appears within 10 cycles after release.
REQ-032 start held high with bcd_in=16'h0059 -> done pulses every 6 cycles, each with bin_out=59.
REQ-033 With the macro defined, bcd_in=16'h1A23 -> err=1 and bin_out=0 at done; without the macro -> err=0 and bin_out=1*1000+10*100+2*10+3=2023.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter, one digit per cycle, MSD first.
// Optional invalid-digit detection is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd2bin_seq #(
    parameter int unsigned NDIG = 4,
    parameter int unsigned BW   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic              busy,
    output logic              done,
    output logic [BW-1:0]     bin_out,
    output logic              err
);

    localparam int unsigned IW = 4 * NDIG;
    localparam int unsigned CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   shift_q;
    logic [BW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      digit;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [BW-1:0]   bin_q, bin_d;
    logic [BW-1:0]   result;

    assign digit = shift_q[IW-1 -: 4];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start outside IDLE is dropped, not queued
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (cnt_q == CW'(NDIG - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic bad_q;
    logic err_q, err_d;

    assign result = bad_q ? '0 : acc_q;
    assign err    = err_q;
`else
    assign result = acc_q;
    assign err    = 1'b0;
`endif

    // Output logic: results are published one cycle after DONE and then held
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
        bin_d  = bin_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        err_d  = err_q;
`endif
        if (state_q == DONE) begin
            bin_d = result;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_d = bad_q;
`endif
        end
    end

    // Datapath: capture, then acc = acc*10 + digit per CONV cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q <= bcd_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                CONV: begin
                    acc_q   <= (acc_q * BW'(10)) + BW'(digit);
                    shift_q <= shift_q << 4;
                    cnt_q   <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    // Sticky invalid-digit flag for the conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
            if (state_q == IDLE && start) begin
                bad_q <= 1'b0;
            end else if (state_q == CONV && digit > 4'd9) begin
                bad_q <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bin_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            bin_q  <= bin_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Scoreboard bench for bcd2bin_seq: driver pushes expected results, monitor pops on done.
// Honours BCD2BIN_DIGIT_CHECK_EN the same way as the design.
module tb_bcd2bin_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic [13:0] bin_out;
    logic        err;

    bcd2bin_seq #(.NDIG(4), .BW(14)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    typedef struct {
        logic [13:0] v;
        logic        e;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          next_ok = 0;
    int          busy_until = 0;
    logic [13:0] last_v = '0;
    logic        last_e = 1'b0;
    int          total = 0;
    int          bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Reference: decimal weight of each nibble at face value, reduced to 14 bits
    function automatic void ref_model(input logic [15:0] b, output logic [13:0] v, output logic e);
        int   sum;
        int   w;
        logic inval;
        logic [15:0] bb;
        bb    = b;
        sum   = 0;
        w     = 1;
        inval = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sum += int'(bb[4*i +: 4]) * w;
            if (bb[4*i +: 4] > 4'd9) inval = 1'b1;
            w *= 10;
        end
        v = 14'(sum % 16384);
        e = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        if (inval) begin
            v = '0;
            e = 1'b1;
        end
`endif
    endfunction

    task automatic drive(input logic s, input logic [15:0] b);
        logic [13:0] v;
        logic        e;
        @(negedge clk);
        #2;
        start  = s;
        bcd_in = b;
        if (s && rst_n && (cyc + 1 >= next_ok)) begin
            ref_model(b, v, e);
            sb.push_back('{v: v, e: e, due: cyc + 1 + 5});
            next_ok    = cyc + 1 + 6;
            busy_until = cyc + 1 + 5;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bin_out !== 14'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL %s: busy=%b done=%b bin_out=%0d err=%b, want all zero", tag, busy, done, bin_out, err);
        end
    endtask

    task automatic pulse_reset(input int hold);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        sb.delete();
        busy_until = 0;
        last_v     = '0;
        last_e     = 1'b0;
        repeat (hold) @(negedge clk);
        #2;
        rst_n   = 1'b1;
        next_ok = cyc + 1;
    endtask

    // Monitor: done timing, result values, held outputs and busy
    always @(negedge clk) begin
        exp_t x;
        if (rst_n) begin
            if (done) begin
                total++;
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    bad++;
                    $display("FAIL spurious_done: cyc=%0d bin_out=%0d, no result due", cyc, bin_out);
                end else begin
                    x = sb.pop_front();
                    total++;
                    if (bin_out !== x.v) begin
                        bad++;
                        $display("FAIL bin_out: cyc=%0d got=%0d want=%0d", cyc, bin_out, x.v);
                    end
                    total++;
                    if (err !== x.e) begin
                        bad++;
                        $display("FAIL err: cyc=%0d got=%b want=%b", cyc, err, x.e);
                    end
                    last_v = x.v;
                    last_e = x.e;
                end
            end else begin
                total++;
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    bad++;
                    $display("FAIL missing_done: cyc=%0d done=0 want=1", cyc);
                    void'(sb.pop_front());
                end
                total++;
                if (bin_out !== last_v || err !== last_e) begin
                    bad++;
                    $display("FAIL hold: cyc=%0d bin_out=%0d err=%b want %0d/%b", cyc, bin_out, err, last_v, last_e);
                end
            end
            total++;
            if (busy !== (cyc < busy_until)) begin
                bad++;
                $display("FAIL busy: cyc=%0d got=%b want=%b", cyc, busy, (cyc < busy_until));
            end
        end
    end

    function automatic logic [15:0] rand_bcd(input logic allow_bad);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = allow_bad ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = '0;
        #1;
        check_reset_vals("reset_state");
        repeat (3) @(negedge clk);
        #2;
        rst_n   = 1'b1;
        next_ok = cyc + 1;

        // Basic values, including boundaries and an invalid nibble
        drive(1'b1, 16'h2024);
        repeat (7) drive(1'b0, rand_bcd(1'b1));
        drive(1'b1, 16'h9999);
        repeat (7) drive(1'b0, rand_bcd(1'b1));
        drive(1'b1, 16'h0000);
        repeat (7) drive(1'b0, rand_bcd(1'b1));
        drive(1'b1, 16'h1A23);
        repeat (7) drive(1'b0, 16'h0000);

        // Second start while converting is ignored
        drive(1'b1, 16'h1234);
        drive(1'b0, 16'h8765);
        drive(1'b1, 16'h5678);
        repeat (8) drive(1'b0, 16'h4321);

        // Held start gives back-to-back conversions
        repeat (18) drive(1'b1, 16'h0059);
        repeat (6) drive(1'b0, 16'h0059);

        // Reset during the second conversion cycle aborts it
        drive(1'b1, 16'h4567);
        drive(1'b0, 16'h0000);
        pulse_reset(2);
        repeat (12) drive(1'b0, 16'h3333);
        drive(1'b1, 16'h0815);
        repeat (7) drive(1'b0, 16'h0000);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_bcd(1'($urandom_range(0, 7) == 0)));
        end
        drive(1'b0, 16'h0000);

        for (int n = 0; n < 20 && sb.size() > 0; n++) drive(1'b0, 16'h0000);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results never arrived", sb.size());
        end
        repeat (3) drive(1'b0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
